snake_dir_queue: RTL
====================

// Module: snake_dir_queue
// PURPOSE
//  Per-player direction controller for the snake game, generalising the single-player button logic in the top level.
//  - Synchronises and debounces the four direction buttons of each of N_PLAYERS players.
//  - Turns each accepted press into a turn request, filtered against the last requested direction.
//  - Buffers requests in a DEPTH-entry FIFO and commits one per game_tick, so quick double turns are not lost.
//  - Sits between the board buttons and snake_game; its dir outputs drive snake_direction.
// PARAMETERS
//  N_PLAYERS  1        number of independent player channels (1..4)
//  DEPTH      2        turn-queue entries per player (power of 2, 2..8)
//  DB_CYCLES  1000000  clk_100MHz cycles a synchronised level must hold to be accepted (>=2)
//  INIT_DIR   2'b00    direction loaded at reset/flush (00 right, 01 up, 10 left, 11 down)
// PORTS
//  clk_100MHz  in   1              system clock
//  reset_n     in   1              asynchronous, active-low reset
//  btn_up      in   N_PLAYERS      raw button, bit p = player p
//  btn_down    in   N_PLAYERS      raw button
//  btn_left    in   N_PLAYERS      raw button
//  btn_right   in   N_PLAYERS      raw button
//  game_tick   in   1              1-cycle strobe, commit point for queued turns
//  flush       in   1              sync clear: empty all queues, dir<=INIT_DIR
//  dir         out  2*N_PLAYERS    committed direction, bits [2p+1:2p] = player p
//  turned      out  N_PLAYERS      1-cycle pulse, dir[p] changed this cycle
//  q_empty     out  N_PLAYERS      queue p holds no requests
//  drop        out  N_PLAYERS      1-cycle pulse, request discarded because queue full
// BEHAVIOUR
//  Reset (reset_n=0, async): dir=INIT_DIR for all players; queues empty; q_empty all 1; turned=0; drop=0.
//   Synchronisers, debounced levels and debounce counters all clear to 0.
//  Input path, per button:
//   - 2-FF synchroniser.
//   - Debounce counter restarts whenever the synchronised level differs from the debounced level.
//   - Debounced level flips once the counter reaches DB_CYCLES-1 with the level unchanged.
//   - Press = rising edge of the debounced level.
//   - Latency: raw rise at cycle 0, held -> debounced rise at cycle DB_CYCLES+2 -> FIFO entry visible at DB_CYCLES+3.
//  Same-cycle presses on one player resolve by priority up > down > left > right; lower-priority presses are discarded.
//  Request filter, per player:
//   - ref = FIFO tail if count>0, else dir.
//   - A request r is rejected silently if r==ref or r==(ref^2'b10), i.e. same or reverse.
//   - Rejections do not pulse drop.
//  Push: a filtered request with count==DEPTH is discarded and drop pulses for 1 cycle; queue unchanged.
//  Commit: on a cycle with game_tick=1 and count>0:
//   - Pop the head; dir takes it next cycle.
//   - turned pulses the same cycle dir changes.
//   - game_tick with an empty queue leaves dir unchanged, turned=0.
//  Simultaneous push+pop on the same game_tick:
//   - Both happen; count unchanged.
//   - Filter ref uses the pre-pop tail.
//   - A full queue accepts the push (pop frees a slot); no drop.
//  flush: takes priority over push and pop. Next cycle: count=0, dir=INIT_DIR.
//   - turned pulses only where dir changed.
//   - Debounce state is kept, so a button held through flush gives no new press.
//  Reset mid-operation: asynchronous return to reset values; no partial FIFO state survives.
//  FIFO: circular, log2(DEPTH)-bit read/write pointers plus count; pointers wrap DEPTH-1 -> 0.
//  Players are fully independent. Only game_tick and flush are shared.
// TESTING (DB_CYCLES=4, DEPTH=2, N_PLAYERS=2, INIT_DIR=00)
//  1. reset_n low 3 cycles -> dir=0000, q_empty=11, turned=00, drop=00; 2-cycle btn_up[0] glitch -> no queue entry.
//  2. Hold btn_up[0] 10 cycles, then game_tick -> entry at cycle 7 after press; dir[1:0]=01 one cycle after tick, turned[0]=1.
//  3. dir=00, press left -> rejected, q_empty stays 1.
//     Press up then left, two ticks -> dir 01 then 10.
//  4. Queue 2 accepted turns, press a 3rd valid turn -> drop[0]=1 for 1 cycle.
//     Repeat with game_tick in the push cycle -> no drop, count stays 2.
//  5. up+left rise on player 1 in one cycle -> only 01 queued; player 0 unaffected by player 1 activity.
//  6. flush with 2 queued and dir=11 -> next cycle q_empty=11, dir=INIT_DIR, turned=1.
//     Assert reset_n mid-queue -> immediate reset values.

Source files
------------

// File: rtl/snake_dir_queue.sv
// Per-player direction controller: synchronise and debounce the buttons, filter turn
// requests against the last requested direction, queue them, commit one per game_tick.
module snake_dir_queue #(
  parameter int          N_PLAYERS = 1,
  parameter int          DEPTH     = 2,
  parameter int          DB_CYCLES = 1000000,
  parameter logic [1:0]  INIT_DIR  = 2'b00
) (
  input  logic                   clk_100MHz,
  input  logic                   reset_n,
  input  logic [N_PLAYERS-1:0]   btn_up,
  input  logic [N_PLAYERS-1:0]   btn_down,
  input  logic [N_PLAYERS-1:0]   btn_left,
  input  logic [N_PLAYERS-1:0]   btn_right,
  input  logic                   game_tick,
  input  logic                   flush,
  output logic [2*N_PLAYERS-1:0] dir,
  output logic [N_PLAYERS-1:0]   turned,
  output logic [N_PLAYERS-1:0]   q_empty,
  output logic [N_PLAYERS-1:0]   drop
);

  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]  DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]    CNT_INC  = (PW+1)'(1);

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    // button index: 0 up, 1 down, 2 left, 3 right
    logic [3:0]    raw;
    logic [3:0]    sync1_q, sync2_q, deb_q, deb_prev_q;
    logic [CW-1:0] cnt_q [4];
    logic [3:0]    press;

    logic          req_vld;
    logic [1:0]    req_dir;

    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, tail_ptr;
    logic [PW:0]   count_q, count_d;
    logic [1:0]    dir_q;
    logic          turned_q, drop_q;
    logic [1:0]    tail, head, ref_dir;
    logic          accept, pop, push, full, drop_d;

    assign raw   = {btn_right[p], btn_left[p], btn_down[p], btn_up[p]};
    assign press = deb_q & ~deb_prev_q;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q    <= '0;
        sync2_q    <= '0;
        deb_q      <= '0;
        deb_prev_q <= '0;
        for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
      end else begin
        sync1_q    <= raw;
        sync2_q    <= sync1_q;
        deb_prev_q <= deb_q;
        // the level must differ for DB_CYCLES consecutive samples before it is taken
        for (int b = 0; b < 4; b++) begin
          if (sync2_q[b] == deb_q[b]) begin
            cnt_q[b] <= '0;
          end else if (cnt_q[b] == DB_LAST) begin
            deb_q[b] <= sync2_q[b];
            cnt_q[b] <= '0;
          end else begin
            cnt_q[b] <= cnt_q[b] + CNT_ONE;
          end
        end
      end
    end

    always_comb begin
      req_vld = 1'b1;
      req_dir = 2'b00;
      if (press[0])      req_dir = 2'b01;
      else if (press[1]) req_dir = 2'b11;
      else if (press[2]) req_dir = 2'b10;
      else if (press[3]) req_dir = 2'b00;
      else               req_vld = 1'b0;
    end

    assign tail_ptr = wr_ptr_q - PTR_ONE;
    assign tail     = mem_q[tail_ptr];
    assign head     = mem_q[rd_ptr_q];
    assign ref_dir  = (count_q != '0) ? tail : dir_q;
    assign accept   = req_vld && (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'b10));
    assign pop      = game_tick && (count_q != '0);
    assign full     = (count_q == CNT_FULL);
    // a pop in the same cycle frees the slot a full queue needs
    assign push     = accept && (!full || pop);
    assign drop_d   = accept && full && !pop;

    always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNT_INC;
      else if (pop && !push) count_d = count_q - CNT_INC;
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
        for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        dir_q    <= INIT_DIR;
        turned_q <= 1'b0;
        drop_q   <= 1'b0;
      end else if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        dir_q    <= INIT_DIR;
        turned_q <= (dir_q != INIT_DIR);
        drop_q   <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= req_dir;
          wr_ptr_q        <= wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_ONE;
          dir_q    <= head;
          turned_q <= (head != dir_q);
        end else begin
          turned_q <= 1'b0;
        end
        count_q <= count_d;
        drop_q  <= drop_d;
      end
    end

    assign dir[2*p +: 2] = dir_q;
    assign turned[p]     = turned_q;
    assign drop[p]       = drop_q;
    assign q_empty[p]    = (count_q == '0);
  end

endmodule
